// File: rtl/qk_feeder_pkg.sv
// qk_feeder_pkg: shared definitions for the MAC-column head sequencer.
//   - chain instruction encodings (2-bit, [1]=execute, [0]=load)
//   - FSM state enum
//   - number of zero pad beats that lead every load sequence
package qk_feeder_pkg;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam int PAD_BEATS = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/qk_feeder.sv
// qk_feeder: drives column 0 of the MAC column chain.
// Loads one key vector per column (preceded by PAD_BEATS zero beats), then
// streams n_q query vectors as execute beats, inserting bubbles while the
// output FIFO is full, waits for the chain to drain and pulses done.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   start             job request (IDLE only), samples key_base/q_base/n_q
//   ofifo_ready       output FIFO can take a result; low -> execute bubble
//   mem_rd/mem_addr   registered SRAM read request (issue stage)
//   mem_rdata         SRAM data, valid the cycle after mem_rd
//   inst_out/q_out    instruction + data beat to the chain (output stage)
//   busy, done        job status; done is a one-cycle pulse
//   exec_cnt          execute beats issued in the current job
module qk_feeder
    import qk_feeder_pkg::*;
#(
    parameter int bw  = 8,
    parameter int pr  = 8,
    parameter int col = 8,
    parameter int aw  = 10,
    parameter int qw  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [aw-1:0]    key_base,
    input  logic [aw-1:0]    q_base,
    input  logic [qw-1:0]    n_q,
    input  logic             ofifo_ready,
    output logic             mem_rd,
    output logic [aw-1:0]    mem_addr,
    input  logic [pr*bw-1:0] mem_rdata,
    output logic [1:0]       inst_out,
    output logic [pr*bw-1:0] q_out,
    output logic             busy,
    output logic             done,
    output logic [qw-1:0]    exec_cnt
);

    localparam int DW = pr * bw;
    // Shared beat counter: LOAD counts beats 1..col+1, DRAIN counts 0..col+3.
    localparam int CW = $clog2(col + 4);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [aw-1:0]   key_q;
    logic [aw-1:0]   qb_q;
    logic [qw-1:0]   nq_q;
    logic [qw-1:0]   exec_cnt_q;
    logic            mem_rd_q;
    logic [aw-1:0]   mem_addr_q;
    logic [1:0]      iss_inst_q;   // instruction travelling with the SRAM read
    logic            iss_pad_q;
    logic [1:0]      inst_out_q;
    logic            out_pad_q;
    logic [DW-1:0]   q_hold_q;     // last beat driven, replayed on bubbles
    logic            busy_q;
    logic            done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            key_q      <= '0;
            qb_q       <= '0;
            nq_q       <= '0;
            exec_cnt_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            iss_inst_q <= INST_IDLE;
            iss_pad_q  <= 1'b0;
            inst_out_q <= INST_IDLE;
            out_pad_q  <= 1'b0;
            q_hold_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Output stage: instruction and pad select follow the issue stage.
            inst_out_q <= iss_inst_q;
            out_pad_q  <= iss_pad_q;
            q_hold_q   <= q_out;

            // Issue stage defaults: no beat this cycle.
            mem_rd_q   <= 1'b0;
            iss_inst_q <= INST_IDLE;
            iss_pad_q  <= 1'b0;
            done_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        key_q      <= key_base;
                        qb_q       <= q_base;
                        nq_q       <= n_q;
                        exec_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        // Load beat 0 (a pad) issues in the cycle after start.
                        iss_inst_q <= INST_LOAD;
                        iss_pad_q  <= 1'b1;
                        cnt_q      <= CW'(1);
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    iss_inst_q <= INST_LOAD;
                    if (cnt_q < CW'(PAD_BEATS)) begin
                        iss_pad_q <= 1'b1;
                    end else begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= key_q + aw'(cnt_q) - aw'(PAD_BEATS);
                    end
                    if (cnt_q == CW'(col + 1)) begin
                        cnt_q   <= '0;
                        state_q <= (nq_q == '0) ? S_DRAIN : S_EXEC;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_EXEC: begin
                    if (ofifo_ready) begin
                        iss_inst_q <= INST_EXEC;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= qb_q + aw'(exec_cnt_q);
                        exec_cnt_q <= exec_cnt_q + qw'(1);
                        if (exec_cnt_q + qw'(1) == nq_q) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // col+4 cycles here = 2 pipeline stages + col+2 after the last beat.
                    if (cnt_q == CW'(col + 3)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // SRAM data only becomes valid in the beat's own output cycle, so the data
    // path is a mux behind the registered instruction/pad select.
    assign q_out    = (inst_out_q == INST_IDLE) ? q_hold_q
                    : (out_pad_q ? '0 : mem_rdata);
    assign inst_out = inst_out_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign exec_cnt = exec_cnt_q;

endmodule
